// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared types and helpers for the player scheduler.
//   ADDR_W     : width of the row-major player address
//   ps_state_t : scheduler FSM states
//   dir_t      : move direction; the encoding doubles as the button bit index
//                (bit0 up, bit1 down, bit2 left, bit3 right)
//   pick_dir   : priority select up > down > left > right
//   move_addr  : one grid step with clamping at the edges (no wrap)
// -----------------------------------------------------------------------------
package player_pkg;

   localparam int ADDR_W = 4;

   typedef enum logic [1:0] {IDLE, ARMED, COMMIT, HOLD} ps_state_t;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   // Caller guarantees at least one bit is set; the fall-through value is
   // only reached for a request of 4'b1000.
   function automatic dir_t pick_dir(input logic [3:0] i_req);
      if (i_req[0])      return DIR_UP;
      else if (i_req[1]) return DIR_DOWN;
      else if (i_req[2]) return DIR_LEFT;
      else               return DIR_RIGHT;
   endfunction

   function automatic logic [ADDR_W-1:0] move_addr(
      input logic [ADDR_W-1:0] i_addr,
      input dir_t              i_dir,
      input int                i_gw,
      input int                i_gh
   );
      int row;
      int col;
      int n;
      row = int'(i_addr) / i_gw;
      col = int'(i_addr) % i_gw;
      case (i_dir)
         DIR_UP:    if (row > 0)        row = row - 1;
         DIR_DOWN:  if (row < i_gh - 1) row = row + 1;
         DIR_LEFT:  if (col > 0)        col = col - 1;
         DIR_RIGHT: if (col < i_gw - 1) col = col + 1;
         default:   ;
      endcase
      n = row * i_gw + col;
      return n[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/input_sync.sv
// -----------------------------------------------------------------------------
// input_sync
// N-bit two-flop synchroniser with a third flop for edge detection.
//   i_clk    : destination clock
//   i_rst_n  : asynchronous active-low reset; all flops load IDLE_VAL
//   i_async  : raw asynchronous inputs
//   o_level  : synchronised level
//   o_rise   : one-cycle pulse on a synchronised 0->1 transition
//   o_fall   : one-cycle pulse on a synchronised 1->0 transition
// IDLE_VAL lets active-low signals (vsync) reset to their inactive level so no
// spurious edge is reported when reset is released.
// -----------------------------------------------------------------------------
module input_sync #(
   parameter int             N        = 5,
   parameter logic [N-1:0]   IDLE_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_async,
   output logic [N-1:0] o_level,
   output logic [N-1:0] o_rise,
   output logic [N-1:0] o_fall
);

   logic [N-1:0] r_meta;
   logic [N-1:0] r_sync;
   logic [N-1:0] r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= IDLE_VAL;
         r_sync <= IDLE_VAL;
         r_prev <= IDLE_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/player_scheduler.sv
// -----------------------------------------------------------------------------
// player_scheduler
// Frame-synchronous sequencer for the renderer's player_address. Button
// requests are latched at any time but only committed after a vsync fall, so
// the address never changes in the middle of a frame.
//   clk            : pixel clock (clk_25 domain)
//   rst            : asynchronous active-low reset
//   vsync          : active-low vertical sync
//   btn_up/down/left/right : raw asynchronous buttons, active-high
//   player_address : current grid cell, row*GRID_W + col
//   frame_tick     : one-cycle strobe per synchronised vsync fall
//   pending        : a move is latched and waits for the next frame_tick
//   state_dbg      : current FSM state
// frame_tick and pending are plain strobes/levels; there is no back-pressure.
// -----------------------------------------------------------------------------
module player_scheduler
   import player_pkg::*;
#(
   parameter int                GRID_W        = 4,
   parameter int                GRID_H        = 4,
   parameter logic [ADDR_W-1:0] START_ADDR    = '0,
   parameter int                REPEAT_FRAMES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_left,
   input  logic              btn_right,
   output logic [ADDR_W-1:0] player_address,
   output logic              frame_tick,
   output logic              pending,
   output ps_state_t         state_dbg
);

   generate
      if (GRID_W * GRID_H > 16) begin : g_bad_grid
         $error("player_scheduler: GRID_W*GRID_H must not exceed 16");
      end
      if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 15) begin : g_bad_repeat
         $error("player_scheduler: REPEAT_FRAMES must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] LP_RPT = 4'(REPEAT_FRAMES);

   // Bit 4 is vsync (idles high), bits 3:0 are the buttons (idle low).
   logic [4:0] w_level;
   logic [4:0] w_rise;
   logic [4:0] w_fall;

   input_sync #(
      .N        (5),
      .IDLE_VAL (5'b10000)
   ) u_sync (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_async ({vsync, btn_right, btn_left, btn_down, btn_up}),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   logic w_unused;
   assign w_unused = ^{w_level[4], w_rise[4], w_fall[3:0]};

   logic [3:0] w_btn_level;
   logic [3:0] w_btn_rise;
   logic [3:0] w_other_rise;

   ps_state_t         r_state;
   dir_t              r_dir;
   logic              r_pending;
   logic              r_tick;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;

   assign w_btn_level  = w_level[3:0];
   assign w_btn_rise   = w_rise[3:0];
   // Rises of any button other than the one currently latched.
   assign w_other_rise = w_btn_rise & ~(4'b0001 << r_dir);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_dir     <= DIR_UP;
         r_pending <= 1'b0;
         r_tick    <= 1'b0;
         r_cnt     <= '0;
         r_addr    <= START_ADDR;
      end else begin
         r_tick <= w_fall[4];
         case (r_state)
            // A rise coinciding with frame_tick is latched here, so it commits
            // on the following frame rather than this one.
            IDLE: begin
               if (|w_btn_rise) begin
                  r_dir     <= pick_dir(w_btn_rise);
                  r_pending <= 1'b1;
                  r_state   <= ARMED;
               end
            end
            ARMED: begin
               if (r_tick) r_state <= COMMIT;
            end
            COMMIT: begin
               r_addr    <= move_addr(r_addr, r_dir, GRID_W, GRID_H);
               r_pending <= 1'b0;
               r_cnt     <= LP_RPT;
               r_state   <= HOLD;
            end
            HOLD: begin
               if (|w_other_rise) begin
                  r_dir     <= pick_dir(w_other_rise);
                  r_pending <= 1'b1;
                  r_state   <= ARMED;
               end else if (!w_btn_level[r_dir]) begin
                  r_state <= IDLE;
               end else if (r_cnt == 4'd0) begin
                  // Auto-repeat: the held button re-arms the same direction.
                  r_pending <= 1'b1;
                  r_state   <= ARMED;
               end else if (r_tick) begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign player_address = r_addr;
   assign frame_tick     = r_tick;
   assign pending        = r_pending;
   assign state_dbg      = r_state;

endmodule

// File: tb/tb_player_scheduler.sv
// -----------------------------------------------------------------------------
// tb_player_scheduler
// Frame-level reference model: every frame the driver pushes the address
// expected before and after that frame's tick; a monitor pops one entry per
// frame_tick and checks the old value one cycle later and the new value two
// cycles later.
// -----------------------------------------------------------------------------
module tb_player_scheduler;
   import player_pkg::*;

   localparam int         GW        = 4;
   localparam int         GH        = 4;
   localparam logic [3:0] START     = 4'd0;
   localparam int         RPT       = 8;
   localparam int         FRAME_LEN = 40;
   localparam int         VS_LOW    = 4;

   logic       clk;
   logic       rst;
   logic       vsync;
   logic [3:0] btn;
   logic [3:0] player_address;
   logic       frame_tick;
   logic       pending;
   ps_state_t  state_dbg;

   player_scheduler #(
      .GRID_W        (GW),
      .GRID_H        (GH),
      .START_ADDR    (START),
      .REPEAT_FRAMES (RPT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .vsync          (vsync),
      .btn_up         (btn[0]),
      .btn_down       (btn[1]),
      .btn_left       (btn[2]),
      .btn_right      (btn[3]),
      .player_address (player_address),
      .frame_tick     (frame_tick),
      .pending        (pending),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];   // {address before tick, address after tick}
   int         n_checks = 0;
   int         n_errors = 0;
   int         tick_cnt = 0;
   logic [3:0] m_addr   = START;
   logic [7:0] mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int prio(input logic [3:0] mask);
      for (int i = 0; i < 4; i++) if (mask[i]) return i;
      return 3;
   endfunction

   function automatic logic [3:0] model_move(input logic [3:0] a, input int d);
      int r;
      int c;
      int n;
      r = int'(a) / GW;
      c = int'(a) % GW;
      if (d == 0 && r > 0)      r--;
      if (d == 1 && r < GH - 1) r++;
      if (d == 2 && c > 0)      c--;
      if (d == 3 && c < GW - 1) c++;
      n = r * GW + c;
      return n[3:0];
   endfunction

   task automatic push_frame(input bit commit, input int d);
      logic [3:0] old;
      old = m_addr;
      if (commit) m_addr = model_move(m_addr, d);
      exp_q.push_back({old, m_addr});
   endtask

   // ---------------- driver ----------------
   // One frame: vsync falls at step 0; buttons change at step 'when'
   // (step 1 makes the button rise coincide with frame_tick).
   task automatic run_frame(input logic [3:0] b, input int when, input bit chk_pend);
      for (int c = 0; c < FRAME_LEN; c++) begin
         @(negedge clk);
         if (c == 0)      vsync = 1'b0;
         if (c == VS_LOW) vsync = 1'b1;
         if (c == when)   btn   = b;
         if (chk_pend && c == when + 4) check("pending_set", pending, 1);
      end
   endtask

   // Press 'mask' in frame 0, keep it through 'h' ticks, release after tick h.
   // Commits fall on ticks 1, 1+(RPT+1), ... while the button was held when
   // the repeat counter expired.
   task automatic episode(input logic [3:0] mask, input int h, input int when);
      int d;
      d = prio(mask);
      push_frame(1'b0, d);
      run_frame(mask, when, 1'b1);
      for (int t = 1; t <= h + 1; t++) begin
         push_frame(((t - 1) % (RPT + 1)) == 0, d);
         if (t == h) run_frame(4'b0000, $urandom_range(8, 35), 1'b0);
         else        run_frame(btn, -1, 1'b0);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && frame_tick === 1'b1) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_tick", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               @(negedge clk);
               check("tick_width", frame_tick, 0);
               check("addr_before", player_address, mon_e[7:4]);
               @(negedge clk);
               check("addr_after", player_address, mon_e[3:0]);
               if (mon_e[7:4] != mon_e[3:0]) check("pending_clear", pending, 0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int t0;

   initial begin
      rst   = 1'b0;
      vsync = 1'b1;
      btn   = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_addr", player_address, START);
      check("rst_pending", pending, 0);
      check("rst_tick", frame_tick, 0);
      check("rst_state", state_dbg, IDLE);
      @(negedge clk);
      rst = 1'b1;

      // Idle frames: exactly three ticks, nothing moves.
      t0 = tick_cnt;
      repeat (3) begin
         push_frame(1'b0, 0);
         run_frame(4'b0000, -1, 1'b0);
      end
      check("idle_tick_count", tick_cnt - t0, 3);
      check("idle_pending", pending, 0);

      // Directed walk through the grid.
      episode(4'b1000, 1, 20);   // right 0 -> 1
      episode(4'b0100, 1, 15);   // left  1 -> 0
      episode(4'b0010, 1, 1);    // down coincident with tick: 0 -> 4 a frame later
      episode(4'b1000, 1, 22);   // right 4 -> 5
      episode(4'b1001, 1, 18);   // up+right together: up wins, 5 -> 1
      episode(4'b1000, 1, 12);   // right 1 -> 2
      episode(4'b1000, 1, 30);   // right 2 -> 3
      episode(4'b0100, 28, 17);  // left held: 2, 1, 0, 0 (clamped)

      // Random episodes.
      for (int e = 0; e < 12; e++) begin
         logic [3:0] mask;
         int         h;
         int         when;
         mask = 4'($urandom_range(1, 15));
         h    = $urandom_range(1, 20);
         when = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(8, 35);
         episode(mask, h, when);
      end

      // Reset while ARMED discards the request.
      if (m_addr == START) episode(4'b1000, 1, 20);
      push_frame(1'b0, 0);
      for (int c = 0; c < FRAME_LEN; c++) begin
         @(negedge clk);
         if (c == 0)      vsync = 1'b0;
         if (c == VS_LOW) vsync = 1'b1;
         if (c == 10)     btn   = 4'b1000;
         if (c == 14) begin
            check("armed_pending", pending, 1);
            check("armed_state", state_dbg, ARMED);
         end
         if (c == 19) begin
            #2 rst = 1'b0;
            #1;
            check("async_rst_pending", pending, 0);
            check("async_rst_addr", player_address, START);
            check("async_rst_state", state_dbg, IDLE);
            btn = 4'b0000;
         end
         if (c == 24) rst = 1'b1;
      end
      m_addr = START;
      repeat (2) begin
         push_frame(1'b0, 0);
         run_frame(4'b0000, -1, 1'b0);
      end
      check("post_rst_addr", player_address, START);

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
